// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a single-port data-cache handshake for plain, byte and
// indirect (LDI/STI) loads and stores, stalls upstream while an access is outstanding,
// and produces the MEM-stage result used for forwarding. Also keeps a saturating
// count of stalled cycles.
module mem_access_stage #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [2:0]           memop,
  input  logic [15:0]          addr_in,
  input  logic [15:0]          store_data,
  input  logic                 clear_count,
  output logic [15:0]          dcache_addr,
  output logic                 dcache_read,
  output logic                 dcache_write,
  output logic [1:0]           dcache_wmask,
  output logic [15:0]          dcache_wdata,
  input  logic [15:0]          dcache_rdata,
  input  logic                 dcache_resp,
  output logic [15:0]          mem_data_out,
  output logic                 mem_done,
  output logic                 mem_stall,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [2:0] OpLdr = 3'b001;
  localparam logic [2:0] OpLdb = 3'b010;
  localparam logic [2:0] OpStr = 3'b011;
  localparam logic [2:0] OpStb = 3'b100;
  localparam logic [2:0] OpLdi = 3'b101;
  localparam logic [2:0] OpSti = 3'b110;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc1 = 2'd1,
    StAcc2 = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [15:0]          addr_q, addr_d;
  logic [15:0]          sdata_q, sdata_d;
  logic [15:0]          ptr_q, ptr_d;
  logic [15:0]          result_q, result_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic        mem_valid;
  logic        op_indirect;
  logic        op_byte_store;
  logic        first_is_read;
  logic        first_is_write;
  logic [15:0] first_result;
  logic [15:0] byte_data;

  // Decode of the incoming instruction and of the latched operation.
  always_comb begin
    mem_valid      = valid_in && (memop != 3'b000) && (memop != 3'b111);
    op_indirect    = (op_q == OpLdi) || (op_q == OpSti);
    op_byte_store  = (op_q == OpStb);
    // Both indirect ops start by reading the pointer word.
    first_is_read  = (op_q == OpLdr) || (op_q == OpLdb) || op_indirect;
    first_is_write = (op_q == OpStr) || (op_q == OpStb);
    byte_data      = addr_q[0] ? {8'h00, dcache_rdata[15:8]} : {8'h00, dcache_rdata[7:0]};
    unique case (op_q)
      OpLdr:   first_result = dcache_rdata;
      OpLdb:   first_result = byte_data;
      default: first_result = sdata_q;
    endcase
  end

  // Access FSM next-state and latched operand updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          state_d = StAcc1;
          op_d    = memop;
          addr_d  = addr_in;
          sdata_d = store_data;
        end
      end
      StAcc1: begin
        if (dcache_resp) begin
          if (op_indirect) begin
            ptr_d   = {dcache_rdata[15:1], 1'b0};
            state_d = StAcc2;
          end else begin
            result_d = first_result;
            state_d  = StDone;
          end
        end
      end
      StAcc2: begin
        if (dcache_resp) begin
          result_d = (op_q == OpLdi) ? dcache_rdata : sdata_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        // Inputs ignored here so the retiring instruction is never re-issued.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Cache request outputs, derived from registered state only.
  always_comb begin
    dcache_addr  = 16'h0000;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    dcache_wmask = 2'b00;
    dcache_wdata = 16'h0000;
    unique case (state_q)
      StAcc1: begin
        dcache_addr  = {addr_q[15:1], 1'b0};
        dcache_read  = first_is_read;
        dcache_write = first_is_write;
        if (op_byte_store) begin
          dcache_wmask = addr_q[0] ? 2'b10 : 2'b01;
          dcache_wdata = {sdata_q[7:0], sdata_q[7:0]};
        end else begin
          dcache_wmask = 2'b11;
          dcache_wdata = sdata_q;
        end
      end
      StAcc2: begin
        dcache_addr  = ptr_q;
        dcache_read  = (op_q == OpLdi);
        dcache_write = (op_q == OpSti);
        dcache_wmask = 2'b11;
        dcache_wdata = sdata_q;
      end
      default: ;
    endcase
  end

  // Pipeline-facing outputs; stall covers the presenting cycle through the last resp.
  always_comb begin
    mem_done     = (state_q == StDone);
    mem_stall    = !reset && (((state_q == StIdle) && mem_valid) ||
                              (state_q == StAcc1) || (state_q == StAcc2));
    if (reset) begin
      mem_data_out = 16'h0000;
    end else if (state_q == StDone) begin
      mem_data_out = result_q;
    end else begin
      mem_data_out = addr_in;
    end
    stall_count  = stall_count_q;
  end

  // Saturating stall counter next value; clear wins over increment.
  always_comb begin
    stall_count_d = stall_count_q;
    if (clear_count) begin
      stall_count_d = '0;
    end else if (mem_stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CntOne;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= 3'b000;
      addr_q        <= 16'h0000;
      sdata_q       <= 16'h0000;
      ptr_q         <= 16'h0000;
      result_q      <= 16'h0000;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      sdata_q       <= sdata_d;
      ptr_q         <= ptr_d;
      result_q      <= result_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: acts as the data cache, applies directed and random
// memory operations and compares every cycle against a transaction-level model.
module tb_mem_access_stage;

  localparam logic [2:0] LDR = 3'd1;
  localparam logic [2:0] LDB = 3'd2;
  localparam logic [2:0] STR = 3'd3;
  localparam logic [2:0] STB = 3'd4;
  localparam logic [2:0] LDI = 3'd5;
  localparam logic [2:0] STI = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [2:0]  memop;
  logic [15:0] addr_in;
  logic [15:0] store_data;
  logic        clear_count;
  logic [15:0] dcache_addr;
  logic        dcache_read;
  logic        dcache_write;
  logic [1:0]  dcache_wmask;
  logic [15:0] dcache_wdata;
  logic [15:0] dcache_rdata;
  logic        dcache_resp;
  logic [15:0] mem_data_out;
  logic        mem_done;
  logic        mem_stall;
  logic [15:0] stall_count;

  int          nvec = 0;
  int          nerr = 0;
  int unsigned cnt_model = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .memop        (memop),
    .addr_in      (addr_in),
    .store_data   (store_data),
    .clear_count  (clear_count),
    .dcache_addr  (dcache_addr),
    .dcache_read  (dcache_read),
    .dcache_write (dcache_write),
    .dcache_wmask (dcache_wmask),
    .dcache_wdata (dcache_wdata),
    .dcache_rdata (dcache_rdata),
    .dcache_resp  (dcache_resp),
    .mem_data_out (mem_data_out),
    .mem_done     (mem_done),
    .mem_stall    (mem_stall),
    .stall_count  (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and update the stall-counter model.
  task automatic clock_edge(input bit stall, input bit clr);
    @(posedge clk);
    if (clr) cnt_model = 0;
    else if (stall && cnt_model < 32'd65535) cnt_model++;
  endtask

  // One full memory operation; lat = cycle of the access (1 = first request cycle) that gets resp.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd,
                        input int lat1, input logic [15:0] rd1,
                        input int lat2, input logic [15:0] rd2, input bit clr);
    logic [15:0] res, e_addr, e_wd, rd;
    logic        e_rd, e_wr;
    logic [1:0]  e_wm;
    int          nacc, lat;
    case (op)
      LDR:     res = rd1;
      LDB:     res = a[0] ? {8'h00, rd1[15:8]} : {8'h00, rd1[7:0]};
      LDI:     res = rd2;
      default: res = sd;
    endcase
    nacc = (op == LDI || op == STI) ? 2 : 1;

    @(negedge clk);
    valid_in = 1'b1; memop = op; addr_in = a; store_data = sd; clear_count = clr;
    dcache_resp = 1'b0; dcache_rdata = 16'($urandom);
    #1;
    check("present_stall", mem_stall, 1);
    check("present_pass", mem_data_out, a);
    check("present_noreq", {dcache_read, dcache_write}, 0);
    check("present_cnt", stall_count, cnt_model);
    clock_edge(1'b1, clr);

    for (int k = 0; k < nacc; k++) begin
      if (k == 0) begin
        e_addr = a & 16'hFFFE;
        e_rd   = (op == LDR || op == LDB || op == LDI || op == STI);
        e_wr   = (op == STR || op == STB);
        e_wm   = (op == STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        e_wd   = (op == STB) ? {sd[7:0], sd[7:0]} : sd;
        lat    = lat1;
        rd     = rd1;
      end else begin
        e_addr = rd1 & 16'hFFFE;
        e_rd   = (op == LDI);
        e_wr   = (op == STI);
        e_wm   = 2'b11;
        e_wd   = sd;
        lat    = lat2;
        rd     = rd2;
      end
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        valid_in = 1'b0; clear_count = 1'b0; memop = 3'($urandom);
        addr_in = 16'($urandom); store_data = 16'($urandom);
        dcache_resp  = (c == lat);
        dcache_rdata = (c == lat) ? rd : 16'($urandom);
        #1;
        check("req_addr", dcache_addr, e_addr);
        check("req_read", dcache_read, e_rd);
        check("req_write", dcache_write, e_wr);
        if (e_wr) begin
          check("req_wmask", dcache_wmask, e_wm);
          check("req_wdata", dcache_wdata, e_wd);
        end
        check("acc_stall", mem_stall, 1);
        check("acc_nodone", mem_done, 0);
        check("acc_pass", mem_data_out, addr_in);
        check("acc_cnt", stall_count, cnt_model);
        clock_edge(1'b1, 1'b0);
      end
    end

    // DONE: present another op and a stray resp; both must be ignored.
    @(negedge clk);
    valid_in = 1'b1; memop = LDR; addr_in = 16'($urandom);
    dcache_resp = 1'b1; dcache_rdata = 16'($urandom);
    #1;
    check("done_pulse", mem_done, 1);
    check("done_nostall", mem_stall, 0);
    check("done_result", mem_data_out, res);
    check("done_noreq", {dcache_read, dcache_write}, 0);
    check("done_cnt", stall_count, cnt_model);
    clock_edge(1'b0, 1'b0);

    @(negedge clk);
    valid_in = 1'b0; dcache_resp = 1'b0; addr_in = 16'($urandom);
    #1;
    check("after_nodone", mem_done, 0);
    check("after_nostall", mem_stall, 0);
    check("after_noreq", {dcache_read, dcache_write}, 0);
    check("after_pass", mem_data_out, addr_in);
    clock_edge(1'b0, 1'b0);
  endtask

  // Cycle with no memory instruction; a stray resp in IDLE must be ignored.
  task automatic idle_cycle();
    logic v;
    @(negedge clk);
    v = 1'($urandom_range(1));
    valid_in = v;
    memop = v ? (($urandom_range(1) == 0) ? 3'd0 : 3'd7) : 3'($urandom);
    addr_in = 16'($urandom); store_data = 16'($urandom);
    dcache_resp = 1'($urandom_range(1)); dcache_rdata = 16'($urandom);
    clear_count = 1'b0;
    #1;
    check("idle_nostall", mem_stall, 0);
    check("idle_noreq", {dcache_read, dcache_write}, 0);
    check("idle_nodone", mem_done, 0);
    check("idle_pass", mem_data_out, addr_in);
    check("idle_cnt", stall_count, cnt_model);
    clock_edge(1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    logic [2:0] op;
    reset = 1'b1; valid_in = 1'b0; memop = 3'd0; addr_in = 16'h1234; store_data = 16'h0;
    clear_count = 1'b0; dcache_rdata = 16'h0; dcache_resp = 1'b0;

    // Reset values, even with a memory op presented.
    @(negedge clk);
    valid_in = 1'b1; memop = LDR;
    #1;
    check("rst_read", dcache_read, 0);
    check("rst_write", dcache_write, 0);
    check("rst_addr", dcache_addr, 0);
    check("rst_wmask", dcache_wmask, 0);
    check("rst_wdata", dcache_wdata, 0);
    check("rst_done", mem_done, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_data", mem_data_out, 0);
    check("rst_cnt", stall_count, 0);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0;
    #1;
    check("rel_pass", mem_data_out, 16'h1234);
    clock_edge(1'b0, 1'b0);

    // Directed cases.
    c0 = int'(cnt_model);
    run_op(LDR, 16'h3005, 16'h0000, 2, 16'hBEEF, 0, 16'h0, 1'b0);
    #2 check("t1_stall_cycles", stall_count, c0 + 3);
    run_op(STB, 16'h4001, 16'h12A5, 1, 16'h0000, 0, 16'h0, 1'b0);
    run_op(STB, 16'h4000, 16'h3C5A, 3, 16'h0000, 0, 16'h0, 1'b0);
    run_op(LDB, 16'h2001, 16'h0000, 1, 16'h80FF, 0, 16'h0, 1'b0);
    run_op(LDB, 16'h2000, 16'h0000, 2, 16'h80FF, 0, 16'h0, 1'b0);
    run_op(STR, 16'h0007, 16'hCAFE, 1, 16'h0000, 0, 16'h0, 1'b0);
    c0 = int'(cnt_model);
    run_op(LDI, 16'h1000, 16'h0000, 1, 16'h5003, 2, 16'h7777, 1'b0);
    #2 check("ldi_stall_cycles", stall_count, c0 + 4);
    run_op(STI, 16'h1000, 16'h4321, 2, 16'h5003, 1, 16'h0000, 1'b0);
    idle_cycle();

    // Reset while a read is outstanding; a late resp must be ignored.
    @(negedge clk);
    valid_in = 1'b1; memop = LDR; addr_in = 16'h3005; dcache_resp = 1'b0;
    #1;
    clock_edge(1'b1, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("mid_read", dcache_read, 1);
    check("mid_addr", dcache_addr, 16'h3004);
    reset = 1'b1;
    #1;
    cnt_model = 0;
    check("mid_rst_read", dcache_read, 0);
    check("mid_rst_stall", mem_stall, 0);
    check("mid_rst_cnt", stall_count, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; dcache_resp = 1'b1; dcache_rdata = 16'hDEAD;
    #1;
    check("late_resp_nodone", mem_done, 0);
    check("late_resp_noread", dcache_read, 0);
    clock_edge(1'b0, 1'b0);
    @(negedge clk);
    dcache_resp = 1'b0;
    #1;
    check("late_resp_nodone2", mem_done, 0);
    check("late_resp_cnt", stall_count, 0);
    clock_edge(1'b0, 1'b0);

    // Counter saturation and clear.
    run_op(LDR, 16'h0100, 16'h0000, 65533, 16'h1111, 0, 16'h0, 1'b0);
    #2 check("sat_fffe", stall_count, 16'hFFFE);
    run_op(STB, 16'h0101, 16'h00AA, 2, 16'h0000, 0, 16'h0, 1'b0);
    #2 check("sat_hold", stall_count, 16'hFFFF);
    run_op(LDR, 16'h0200, 16'h0000, 2, 16'h2222, 0, 16'h0, 1'b1);
    #2 check("clr_count", stall_count, 2);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(6, 1));
      run_op(op, 16'($urandom), 16'($urandom), $urandom_range(4, 1), 16'($urandom),
             $urandom_range(4, 1), 16'($urandom), 1'($urandom_range(7) == 0));
      if ($urandom_range(1) == 1) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
